// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Imported by fetch and decode.
package pipeline_pkg;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'd0;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_id_t;

  function automatic logic [31:0] pc_next(
    input logic [31:0] pc
  );
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_skid_buffer.sv
// One-entry data+valid holding register.
// Load, drain and clear; clear wins.
module skid_buffer #(
  parameter int unsigned W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // valid flag: set on load, dropped on drain or clear
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  // payload captured whenever a load is requested
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issue, align, skid, squash.
// Presents the IF/ID register to decode.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned SQUASH_DEPTH = 1,
  parameter logic [31:0] RESET_PC     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  localparam int SW =
    (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);
  localparam logic [SW-1:0] SQ_LOAD = SW'(SQUASH_DEPTH);

  logic          r_req_valid;
  logic [31:0]   r_req_pc;
  logic [SW-1:0] r_squash;
  if_id_t        r_ifid;

  logic          w_rd;
  logic          w_skid_valid;
  logic          w_skid_load;
  logic          w_skid_drain;
  logic [63:0]   w_skid_data;
  logic [31:0]   w_skid_instr;
  logic [31:0]   w_skid_pc;

  assign w_rd      = !rst && !stall && !w_skid_valid;
  assign imem_rd   = w_rd;
  assign imem_addr = pc_in;

  assign w_skid_load  = !flush && stall && r_req_valid;
  assign w_skid_drain = !flush && !stall && w_skid_valid;
  assign w_skid_instr = w_skid_data[63:32];
  assign w_skid_pc    = w_skid_data[31:0];

  skid_buffer #(.W(64)) u_skid (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (flush),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_data  ({imem_data, r_req_pc}),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // in-flight request: pc and whether its data is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_valid <= 1'b0;
      r_req_pc    <= RESET_PC;
    end else begin
      r_req_valid <= w_rd && !flush && (r_squash == '0);
      if (w_rd) begin
        r_req_pc <= pc_in;
      end
    end
  end

  // squash counter covers the redirect latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_squash <= '0;
    end else if (flush) begin
      r_squash <= SQ_LOAD;
    end else if (w_rd && (r_squash != '0)) begin
      r_squash <= r_squash - 1'b1;
    end
  end

  // IF/ID register: skid first, then fresh data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid <= '{1'b0, NOP_INSTR, RESET_PC,
                  pc_next(RESET_PC)};
    end else if (flush) begin
      r_ifid.valid <= 1'b0;
    end else if (!stall) begin
      if (w_skid_valid) begin
        r_ifid <= '{1'b1, w_skid_instr, w_skid_pc,
                    pc_next(w_skid_pc)};
      end else if (r_req_valid) begin
        r_ifid <= '{1'b1, imem_data, r_req_pc,
                    pc_next(r_req_pc)};
      end else begin
        r_ifid.valid <= 1'b0;
      end
    end
  end

  assign if_valid = r_ifid.valid;
  assign if_instr = r_ifid.instr;
  assign if_pc    = r_ifid.pc;
  assign if_pc4   = r_ifid.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Table for fetch/stall, hand steps for the rest.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fetch_stage #(
    .SQUASH_DEPTH (1),
    .RESET_PC     (32'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .imem_addr (imem_addr),
    .imem_rd   (imem_rd),
    .imem_data (imem_data),
    .stall     (stall),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_pc4    (if_pc4)
  );

  always #5 clk = ~clk;

  // synchronous memory: word = 0x1000 + address
  always @(posedge clk) begin
    if (imem_rd) imem_data <= 32'h1000 + imem_addr;
  end

  typedef struct {
    logic        r;
    logic        s;
    logic        f;
    logic [31:0] pc;
    logic        erd;
    logic        ev;
    logic        ck;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ep4;
  } vec_t;

  vec_t tbl [12];

  task automatic cmp(input string fld,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL c%0d %s got=%h want=%h",
               cyc, fld, got, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst   = v.r;
    stall = v.s;
    flush = v.f;
    pc_in = v.pc;
    #1;
    cmp("imem_rd", 32'(imem_rd), 32'(v.erd));
    cmp("if_valid", 32'(if_valid), 32'(v.ev));
    if (v.ck) begin
      cmp("if_instr", if_instr, v.ei);
      cmp("if_pc", if_pc, v.ep);
      cmp("if_pc4", if_pc4, v.ep4);
    end
    cyc++;
  endtask

  task automatic hs(input logic r, s, f,
                    input logic [31:0] pc,
                    input logic erd, ev, ck,
                    input logic [31:0] ei, ep, ep4);
    vec_t v;
    v = '{r, s, f, pc, erd, ev, ck, ei, ep, ep4};
    step(v);
  endtask

  initial begin
    // reset, straight-line fetch, 3-cycle stall with skid
    tbl[0]  = '{1,0,0,32'h00, 0,0,1, 32'h0000,32'h00,32'h04};
    tbl[1]  = '{0,0,0,32'h00, 1,0,1, 32'h0000,32'h00,32'h04};
    tbl[2]  = '{0,0,0,32'h04, 1,0,0, 32'h0,   32'h0, 32'h0};
    tbl[3]  = '{0,0,0,32'h08, 1,1,1, 32'h1000,32'h00,32'h04};
    tbl[4]  = '{0,1,0,32'h0C, 0,1,1, 32'h1004,32'h04,32'h08};
    tbl[5]  = '{0,1,0,32'h0C, 0,1,1, 32'h1004,32'h04,32'h08};
    tbl[6]  = '{0,1,0,32'h0C, 0,1,1, 32'h1004,32'h04,32'h08};
    tbl[7]  = '{0,0,0,32'h0C, 0,1,1, 32'h1004,32'h04,32'h08};
    tbl[8]  = '{0,0,0,32'h0C, 1,1,1, 32'h1008,32'h08,32'h0C};
    tbl[9]  = '{0,0,0,32'h10, 1,0,0, 32'h0,   32'h0, 32'h0};
    tbl[10] = '{0,0,0,32'h14, 1,1,1, 32'h100C,32'h0C,32'h10};
    tbl[11] = '{0,0,0,32'h18, 1,1,1, 32'h1010,32'h10,32'h14};

    for (int i = 0; i < 12; i++) step(tbl[i]);

    // flush at 0x20: 0x1C in flight, 0x20/0x24 squashed
    hs(0,0,0,32'h01C, 1,1,1, 32'h1014,32'h14,32'h18);
    hs(0,0,1,32'h020, 1,1,1, 32'h1018,32'h18,32'h1C);
    hs(0,0,0,32'h024, 1,0,0, 0,0,0);
    hs(0,0,0,32'h100, 1,0,0, 0,0,0);
    hs(0,0,0,32'h104, 1,0,0, 0,0,0);
    hs(0,0,0,32'h108, 1,1,1, 32'h1100,32'h100,32'h104);

    // flush while stalled with the skid full
    hs(0,1,0,32'h10C, 0,1,1, 32'h1104,32'h104,32'h108);
    hs(0,1,1,32'h10C, 0,1,1, 32'h1104,32'h104,32'h108);
    hs(0,0,0,32'h10C, 1,0,0, 0,0,0);
    hs(0,0,0,32'h200, 1,0,0, 0,0,0);
    hs(0,0,0,32'h204, 1,0,0, 0,0,0);

    // pc+4 wraps at the top of the address space
    hs(0,0,0,32'hFFFFFFFC, 1,1,1, 32'h1200,32'h200,32'h204);
    hs(0,0,0,32'h0, 1,1,1, 32'h1204,32'h204,32'h208);
    hs(0,0,0,32'h4, 1,1,1, 32'h00000FFC,32'hFFFFFFFC,32'h0);

    // reset one cycle after a flush clears the squash
    hs(0,0,1,32'h040, 1,1,1, 32'h1000,32'h0,32'h4);
    hs(1,0,0,32'h044, 0,0,0, 0,0,0);
    hs(0,0,0,32'h300, 1,0,1, 32'h0,32'h0,32'h4);
    hs(0,0,0,32'h304, 1,0,1, 32'h0,32'h0,32'h4);
    hs(0,0,0,32'h308, 1,1,1, 32'h1300,32'h300,32'h304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC, issues a synchronous instruction-memory read, and aligns the returned word with its PC.
- Presents an IF/ID register (instruction, pc, pc+4, valid) to decode.
- Handles decode stalls with a one-entry skid buffer and squashes wrong-path fetches when stage 3 redirects the PC.

Parameters:
- SQUASH_DEPTH, 1, number of request cycles after the flush cycle whose fetches are discarded; covers the one-cycle PC redirect latency.
- RESET_PC, 32'd0, value of if_pc while no valid instruction has been presented.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- pc_in  input  32  current PC from the program counter.
- imem_addr  output  32  instruction-memory read address.
- imem_rd  output  1  memory read enable; data returns the next cycle.
- imem_data  input  32  read data, valid the cycle after imem_rd=1.
- stall  input  1  decode cannot accept; hold the IF/ID register.
- flush  input  1  stage-3 branch taken; discard in-flight and younger fetches.
- if_valid  output  1  IF/ID register holds a real instruction.
- if_instr  output  32  fetched instruction.
- if_pc  output  32  address of if_instr.
- if_pc4  output  32  if_pc + 4, modulo 2^32.

Behaviour:
- Reset:
  - if_valid=0, if_instr=0, if_pc=RESET_PC, if_pc4=RESET_PC+4.
  - req_valid=0, skid_valid=0, squash counter=0.
  - rst has priority over every other input.
- Read issue:
  - imem_addr=pc_in (combinational).
  - imem_rd = !rst && !stall && !skid_valid.
  - The PC source must hold pc_in whenever imem_rd=0.
- Request register, updated when imem_rd=1:
  - req_pc<=pc_in.
  - req_valid<=(squash==0 && !flush).
  - When imem_rd=0, req_valid<=0.
- Response cycle (req_valid=1), imem_data valid:
  - !stall and skid empty: load IF/ID with {imem_data, req_pc, req_pc+4}; if_valid<=1.
  - stall: capture into skid {imem_data, req_pc}; skid_valid<=1. The IF/ID register holds.
- Skid drain: on the first !stall cycle with skid_valid=1, load IF/ID from skid and clear skid_valid. No new request is issued that cycle.
- No valid input while !stall: if_valid<=0 (bubble).
- Stall with no response: IF/ID holds unchanged, including when if_valid=0.
- Flush, priority over stall:
  - if_valid<=0, skid_valid<=0, req_valid<=0.
  - squash<=SQUASH_DEPTH.
  - Each later cycle with imem_rd=1 and squash>0 decrements squash and issues a non-valid request.
  - Flush while squash>0 reloads SQUASH_DEPTH.
- Latency: pc_in at cycle N appears on if_instr at the end of cycle N+1 (visible at N+2) when there is no stall or flush.
- Arithmetic: all 32-bit unsigned; pc+4 wraps 0xFFFFFFFC -> 0x00000000. No alignment checks.
- Stall and flush in the same cycle: flush wins, and stall is ignored for that cycle.
- Reset mid-stall or mid-squash: all state returns to reset values the next cycle.

Decomposition:
- Shared package (pipeline_pkg):
  - constant PC_STEP=4.
  - constant NOP_INSTR=32'd0.
  - typedef if_id_t {valid, instr[31:0], pc[31:0], pc4[31:0]}, reused by decode.
- One natural sub-module: skid_buffer, a one-entry data+valid holding register with load/drain/clear.
- Request tracking and the squash counter stay in fetch_stage.

Test Plan:
- Straight-line fetch: after rst, pc_in 0,4,8,12 on consecutive cycles, memory returns 0x1000+addr. Required: if_valid=1 from cycle 2; if_instr 0x1000, 0x1004, 0x1008, 0x100C; if_pc4 4, 8, 12, 16.
- Stall with skid: assert stall for 3 cycles while the response for pc 0x8 is in flight. Required:
  - imem_rd=0 during stall.
  - if_instr holds the 0x4 instruction.
  - The 0x8 instruction appears on the first cycle after stall drops.
  - The 0xC request is issued one cycle later, with nothing lost or duplicated.
- Flush: assert flush for 1 cycle at pc 0x20, then pc_in=0x100. Required:
  - if_valid=0 next cycle.
  - Fetches for 0x20 and 0x24 are never presented.
  - The first valid if_pc after the flush is 0x100.
- Flush during stall with skid full. Required: skid cleared and if_valid=0 next cycle; the stalled instruction never appears.
- Wrap: pc_in=0xFFFFFFFC. Required: if_pc4=0x00000000.
- Reset mid-squash: rst one cycle after flush. Required: all outputs at reset values; the next fetch after rst deasserts is presented normally, with no residual squash.
